// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared types for the ARM pipeline control block
package arm_pkg;

  // Widest register index the shadow entries can hold; REG_ADDR_W must not exceed it.
  localparam int REG_IDX_W = 8;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] dest;
    logic                 wb_en;
    logic                 mem_r_en;
    logic                 mem_w_en;
    logic                 branch;
    logic [REG_IDX_W-1:0] src1;
    logic [REG_IDX_W-1:0] src2;
    logic                 two_src;
  } shadow_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

  typedef enum logic {
    M_IDLE = 1'b0,
    M_WAIT = 1'b1
  } mem_state_t;

  // A source reads a register that an in-flight entry is going to write.
  function automatic logic src_match(input shadow_t e, input logic [REG_IDX_W-1:0] src,
                                     input logic used);
    return used & e.valid & e.wb_en & (e.dest == src);
  endfunction

endpackage

// File: rtl/arm_fwd_unit.sv
// rtl/arm_fwd_unit.sv - EXE operand forwarding compare (used with ARM_FORWARDING_EN)
module arm_fwd_unit
  import arm_pkg::*;
(
  input  shadow_t  exe_i,
  input  shadow_t  mem_i,
  input  shadow_t  wb_i,
  output fwd_sel_t sel_a,
  output fwd_sel_t sel_b
);

  // Only the routing-relevant fields are read; the rest are carried for symmetry.
  logic unused_fields;
  assign unused_fields = ^{exe_i, mem_i, wb_i};

  // MEM result wins over WB; a MEM load never matches here because ID stalls on load-use.
  function automatic fwd_sel_t pick(input shadow_t m, input shadow_t w,
                                    input logic [REG_IDX_W-1:0] src, input logic used);
    if (src_match(m, src, used) && !m.mem_r_en) begin
      return FWD_MEM;
    end
    if (src_match(w, src, used)) begin
      return FWD_WB;
    end
    return FWD_RF;
  endfunction

  // Select operand sources for the instruction currently in EXE.
  always_comb begin
    sel_a = pick(mem_i, wb_i, exe_i.src1, exe_i.valid);
    sel_b = pick(mem_i, wb_i, exe_i.src2, exe_i.valid & exe_i.two_src);
  end

endmodule

// File: rtl/arm_pipe_ctrl.sv
// rtl/arm_pipe_ctrl.sv - stall/flush/forward control for the 5-stage core (ARM_FORWARDING_EN)
module arm_pipe_ctrl
  import arm_pkg::*;
#(
  parameter int REG_ADDR_W  = 4,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_two_src,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_wb_en,
  input  logic                  id_mem_r_en,
  input  logic                  id_mem_w_en,
  input  logic                  id_branch,
  input  logic                  mem_ready,
  output logic                  freeze_front,
  output logic                  bubble_id,
  output logic                  flush,
  output logic                  branch_taken,
  output logic                  stall_all,
  output logic [1:0]            fwd_sel_a,
  output logic [1:0]            fwd_sel_b,
  output logic                  mem_timeout
);

  // Counter holds 0..MEM_TIMEOUT; the wait ends on the cycle the next count would reach the limit.
  localparam int               CNT_W      = $clog2(MEM_TIMEOUT + 2);
  localparam bit               TIMEOUT_EN = (MEM_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST   = (MEM_TIMEOUT == 0) ? '0 : CNT_W'(MEM_TIMEOUT - 1);

  shadow_t          id_entry;
  shadow_t          exe_q, exe_d, mem_q, mem_d, wb_q, wb_d;
  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             hazard, mem_op, timeout_hit, stall, take_branch, bubble;

  logic unused_fields;
  assign unused_fields = ^{exe_q, mem_q, wb_q};

  // Pack the ID decode into shadow-entry form; ID always carries a real (possibly NOP) slot.
  always_comb begin
    id_entry          = '0;
    id_entry.valid    = 1'b1;
    id_entry.dest     = REG_IDX_W'(id_dest);
    id_entry.wb_en    = id_wb_en;
    id_entry.mem_r_en = id_mem_r_en;
    id_entry.mem_w_en = id_mem_w_en;
    id_entry.branch   = id_branch;
    id_entry.src1     = REG_IDX_W'(id_src1);
    id_entry.src2     = REG_IDX_W'(id_src2);
    id_entry.two_src  = id_two_src;
  end

  assign mem_op      = mem_q.valid & (mem_q.mem_r_en | mem_q.mem_w_en);
  assign timeout_hit = TIMEOUT_EN & (state_q == M_WAIT) & ~mem_ready & (cnt_q == CNT_LAST);
  assign stall       = mem_op & ~mem_ready & ~timeout_hit;
  assign take_branch = exe_q.valid & exe_q.branch & ~stall;
  assign bubble      = hazard & ~take_branch & ~stall;

  // RAW detection for the ID instruction against in-flight writers.
  always_comb begin
    hazard = 1'b0;
`ifdef ARM_FORWARDING_EN
    hazard = (src_match(exe_q, id_entry.src1, 1'b1) |
              src_match(exe_q, id_entry.src2, id_two_src)) & exe_q.mem_r_en;
`else
    hazard = src_match(exe_q, id_entry.src1, 1'b1) |
             src_match(exe_q, id_entry.src2, id_two_src) |
             src_match(mem_q, id_entry.src1, 1'b1) |
             src_match(mem_q, id_entry.src2, id_two_src);
`endif
  end

  // Shadow pipeline advances with the real one; bubbles and flushes enter EXE as empty slots.
  always_comb begin
    exe_d = exe_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!stall) begin
      wb_d  = mem_q;
      mem_d = exe_q;
      exe_d = (bubble | take_branch) ? '0 : id_entry;
    end
  end

  // Memory-wait FSM: track how long MEM has been waiting and give up after the timeout.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      M_IDLE: begin
        if (mem_op && !mem_ready) begin
          state_d = M_WAIT;
          cnt_d   = '0;
        end
      end
      M_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_ready || !mem_op) begin
          state_d = M_IDLE;
        end else if (timeout_hit) begin
          state_d   = M_IDLE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = M_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      exe_q     <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      state_q   <= M_IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      exe_q     <= exe_d;
      mem_q     <= mem_d;
      wb_q      <= wb_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign freeze_front = bubble;
  assign bubble_id    = bubble;
  assign flush        = take_branch;
  assign branch_taken = take_branch;
  assign stall_all    = stall;
  assign mem_timeout  = timeout_q;

`ifdef ARM_FORWARDING_EN
  fwd_sel_t sel_a, sel_b;

  arm_fwd_unit u_fwd (
    .exe_i (exe_q),
    .mem_i (mem_q),
    .wb_i  (wb_q),
    .sel_a (sel_a),
    .sel_b (sel_b)
  );

  assign fwd_sel_a = sel_a;
  assign fwd_sel_b = sel_b;
`else
  assign fwd_sel_a = FWD_RF;
  assign fwd_sel_b = FWD_RF;
`endif

endmodule
